// File: rtl/btn_debounce_repeat.sv
// btn_debounce_repeat: N-channel push-button conditioner.
// Each channel synchronizes its raw pad, debounces it into a clean level,
// and emits 1-cycle press / release / long-press / auto-repeat strobes.
//
// Ports:
//   clk         in   system clock, posedge
//   reset_p     in   asynchronous active-high reset
//   btn_raw     in   [N_BTN] raw pads, async to clk
//   btn_level   out  [N_BTN] debounced level
//   btn_press   out  [N_BTN] strobe, first cycle level reads 1
//   btn_release out  [N_BTN] strobe, first cycle level reads 0
//   btn_long    out  [N_BTN] strobe LONG_CYC cycles after press
//   btn_repeat  out  [N_BTN] strobe every REPEAT_CYC cycles after long

// One channel. All outputs are registered and change on the same edge
// as the debounced level, so strobes line up with btn_level.
module btn_debounce_repeat_ch #(
  parameter int DEBOUNCE_CYC = 1_000_000,  // must be >= 2
  parameter int LONG_CYC     = 100_000_000,
  parameter int REPEAT_CYC   = 20_000_000
) (
  input  logic clk,
  input  logic reset_p,
  input  logic raw,
  output logic lvl_o,
  output logic press_o,
  output logic rel_o,
  output logic long_o,
  output logic rpt_o
);
  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int H_W  = $clog2(LONG_CYC + 1);
  localparam int R_W  = $clog2(REPEAT_CYC + 1);
  // Thresholds compare against the pre-increment value so the toggle/strobe
  // lands on the edge where the count would reach the threshold.
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [H_W-1:0]  H_LAST  = H_W'(LONG_CYC - 1);
  localparam logic [R_W-1:0]  R_LAST  = R_W'(REPEAT_CYC - 1);

  typedef enum logic [1:0] {IDLE, HELD, LONG} state_e;

  logic            meta_q, sync_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [H_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [R_W-1:0]  rep_cnt_q, rep_cnt_d;
  state_e          state_q, state_d;
  logic            lvl_q, lvl_d, press_q, press_d, rel_q, rel_d;
  logic            long_q, long_d, rpt_q, rpt_d;
  logic            rise, fall;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      meta_q     <= 1'b0;
      sync_q     <= 1'b0;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      state_q    <= IDLE;
      lvl_q      <= 1'b0;
      press_q    <= 1'b0;
      rel_q      <= 1'b0;
      long_q     <= 1'b0;
      rpt_q      <= 1'b0;
    end else begin
      meta_q     <= raw;
      sync_q     <= meta_q;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      state_q    <= state_d;
      lvl_q      <= lvl_d;
      press_q    <= press_d;
      rel_q      <= rel_d;
      long_q     <= long_d;
      rpt_q      <= rpt_d;
    end
  end

  always_comb begin
    db_cnt_d   = '0;
    lvl_d      = lvl_q;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    state_d    = state_q;
    long_d     = 1'b0;
    rpt_d      = 1'b0;

    // Any disagreement run shorter than the window is discarded.
    if (sync_q != lvl_q) begin
      if (db_cnt_q == DB_LAST) lvl_d = ~lvl_q;
      else                     db_cnt_d = db_cnt_q + 1'b1;
    end

    rise    = lvl_d & ~lvl_q;
    fall    = ~lvl_d & lvl_q;
    press_d = rise;
    rel_d   = fall;

    unique case (state_q)
      IDLE: if (rise) begin
        state_d    = HELD;
        hold_cnt_d = '0;
      end
      HELD: begin
        hold_cnt_d = hold_cnt_q + 1'b1;
        if (hold_cnt_q == H_LAST) begin
          long_d    = 1'b1;
          state_d   = LONG;
          rep_cnt_d = '0;
        end
      end
      LONG: begin
        if (rep_cnt_q == R_LAST) begin
          rpt_d     = 1'b1;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Release wins over a long/repeat threshold hit on the same edge.
    if (fall) begin
      state_d    = IDLE;
      hold_cnt_d = '0;
      rep_cnt_d  = '0;
      long_d     = 1'b0;
      rpt_d      = 1'b0;
    end
  end

  assign lvl_o   = lvl_q;
  assign press_o = press_q;
  assign rel_o   = rel_q;
  assign long_o  = long_q;
  assign rpt_o   = rpt_q;
endmodule

module btn_debounce_repeat #(
  parameter int N_BTN        = 4,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 100_000_000,
  parameter int REPEAT_CYC   = 20_000_000
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic [N_BTN-1:0] btn_repeat
);
  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_debounce_repeat_ch #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .LONG_CYC    (LONG_CYC),
      .REPEAT_CYC  (REPEAT_CYC)
    ) u_ch (
      .clk    (clk),
      .reset_p(reset_p),
      .raw    (btn_raw[g]),
      .lvl_o  (btn_level[g]),
      .press_o(btn_press[g]),
      .rel_o  (btn_release[g]),
      .long_o (btn_long[g]),
      .rpt_o  (btn_repeat[g])
    );
  end
endmodule
